// File: rtl/cline_mem_arbiter.sv
// cline_mem_arbiter: shares one cacheline memory port between the demand path
// and the next-line prefetcher. Demand wins at grant time, a granted
// transaction runs to mem_resp without preemption, and a demand read and a
// prefetch of the same line are merged into a single memory read.
module cline_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  // demand requester
  input  logic              dem_read,
  input  logic              dem_write,
  input  logic [ADDR_W-1:0] dem_address,
  input  logic [LINE_W-1:0] dem_wdata,
  output logic [LINE_W-1:0] dem_rdata,
  output logic              dem_resp,
  // prefetch requester
  input  logic              pf_read,
  input  logic [ADDR_W-1:0] pf_address,
  output logic [LINE_W-1:0] pf_rdata,
  output logic              pf_resp,
  // memory side
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  // A cacheline is 32 bytes, so the low five address bits select a byte
  // within the line and are cleared before going to memory.
  localparam int OFF_W = 5;
  localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-OFF_W){1'b1}}, {OFF_W{1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DEM   = 2'd1,
    PF    = 2'd2,
    MERGE = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                op_write_q, op_write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;

  logic                same_line;
  logic                busy;

  assign same_line = ((dem_address & LINE_MASK) == (pf_address & LINE_MASK));

  // State and request latch; requester inputs only reach the latch at grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      op_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      op_write_q <= op_write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  // Grant decision in IDLE (demand first, merge same-line reads), otherwise
  // hold the latched transaction until memory completes it.
  always_comb begin
    state_d    = state_q;
    op_write_d = op_write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    case (state_q)
      IDLE: begin
        if (dem_write) begin
          // dem_read alongside dem_write is an illegal combination; write wins.
          state_d    = DEM;
          op_write_d = 1'b1;
          addr_d     = dem_address & LINE_MASK;
          wdata_d    = dem_wdata;
        end else if (dem_read && pf_read && same_line) begin
          state_d    = MERGE;
          op_write_d = 1'b0;
          addr_d     = dem_address & LINE_MASK;
        end else if (dem_read) begin
          // A concurrent prefetch to a different line keeps waiting.
          state_d    = DEM;
          op_write_d = 1'b0;
          addr_d     = dem_address & LINE_MASK;
        end else if (pf_read) begin
          state_d    = PF;
          op_write_d = 1'b0;
          addr_d     = pf_address & LINE_MASK;
        end
      end
      DEM, PF, MERGE: begin
        if (mem_resp) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory request and completion routing; responses follow mem_resp in the
  // same cycle, and a mem_resp seen in IDLE routes nowhere.
  always_comb begin
    busy        = (state_q != IDLE);
    mem_read    = busy && !op_write_q;
    mem_write   = busy && op_write_q;
    mem_address = addr_q;
    mem_wdata   = wdata_q;
    dem_resp    = mem_resp && ((state_q == DEM) || (state_q == MERGE));
    pf_resp     = mem_resp && ((state_q == PF) || (state_q == MERGE));
    dem_rdata   = dem_resp ? mem_rdata : '0;
    pf_rdata    = pf_resp ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_cline_mem_arbiter.sv
// tb_cline_mem_arbiter: directed scenarios with literal expectations plus a
// transaction-level model of the arbiter that is compared on every cycle.
`timescale 1ns/1ps
module tb_cline_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  logic              clk = 1'b0;
  logic              rst;
  logic              dem_read, dem_write;
  logic [ADDR_W-1:0] dem_address;
  logic [LINE_W-1:0] dem_wdata;
  logic [LINE_W-1:0] dem_rdata;
  logic              dem_resp;
  logic              pf_read;
  logic [ADDR_W-1:0] pf_address;
  logic [LINE_W-1:0] pf_rdata;
  logic              pf_resp;
  logic              mem_read, mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_resp;

  int n_checks = 0;
  int n_fail   = 0;
  bit run      = 1'b0;

  always #5 clk = ~clk;

  cline_mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .dem_read   (dem_read),
    .dem_write  (dem_write),
    .dem_address(dem_address),
    .dem_wdata  (dem_wdata),
    .dem_rdata  (dem_rdata),
    .dem_resp   (dem_resp),
    .pf_read    (pf_read),
    .pf_address (pf_address),
    .pf_rdata   (pf_rdata),
    .pf_resp    (pf_resp),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_address(mem_address),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_resp   (mem_resp)
  );

  task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // One outstanding memory transaction described by who is waiting for it.
  bit              m_busy;
  bit              m_to_dem, m_to_pf, m_write;
  int unsigned     m_line;          // line number = byte address / 32
  logic [LINE_W-1:0] m_wdata;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_to_dem = 0; m_to_pf = 0; m_write = 0; m_line = 0; m_wdata = '0;
    end else if (m_busy) begin
      if (mem_resp) m_busy = 0;
    end else if (dem_write) begin
      m_busy = 1; m_to_dem = 1; m_to_pf = 0; m_write = 1;
      m_line = dem_address / 32; m_wdata = dem_wdata;
    end else if (dem_read) begin
      m_busy = 1; m_to_dem = 1; m_write = 0; m_line = dem_address / 32;
      m_to_pf = pf_read && (pf_address / 32 == dem_address / 32);
    end else if (pf_read) begin
      m_busy = 1; m_to_dem = 0; m_to_pf = 1; m_write = 0; m_line = pf_address / 32;
    end
  end

  // Compare DUT against the model in the middle of every cycle.
  always @(negedge clk) begin
    if (run && !rst) begin
      check("cmp_mem_read",  mem_read,  m_busy && !m_write);
      check("cmp_mem_write", mem_write, m_busy && m_write);
      if (m_busy) check("cmp_mem_address", mem_address, m_line * 32);
      if (m_busy && m_write) check("cmp_mem_wdata", mem_wdata, m_wdata);
      check("cmp_dem_resp", dem_resp, m_busy && m_to_dem && mem_resp);
      check("cmp_pf_resp",  pf_resp,  m_busy && m_to_pf && mem_resp);
      if (m_busy && m_to_dem && mem_resp && !m_write) check("cmp_dem_rdata", dem_rdata, mem_rdata);
      if (m_busy && m_to_pf && mem_resp) check("cmp_pf_rdata", pf_rdata, mem_rdata);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    dem_read = 0; dem_write = 0; pf_read = 0; mem_resp = 0;
  endtask

  initial begin
    logic [LINE_W-1:0] a5, wpat, d1, d2, d3, d4;
    a5   = {32{8'hA5}};
    wpat = {2{128'h00112233445566778899AABBCCDDEEFF}};
    d1   = {8{32'hDEAD0001}};
    d2   = {8{32'hBEEF0002}};
    d3   = {8{32'hCAFE0003}};
    d4   = {8{32'h5A5A0004}};

    rst = 1; idle_inputs();
    dem_address = '0; pf_address = '0; dem_wdata = '0; mem_rdata = d4;
    #3;
    // Reset state: everything zero even with mem_rdata non-zero.
    check("rst_mem_read",    mem_read,    0);
    check("rst_mem_write",   mem_write,   0);
    check("rst_mem_address", mem_address, 0);
    check("rst_mem_wdata",   mem_wdata,   0);
    check("rst_dem_resp",    dem_resp,    0);
    check("rst_pf_resp",     pf_resp,     0);
    check("rst_dem_rdata",   dem_rdata,   0);
    check("rst_pf_rdata",    pf_rdata,    0);
    tick(); rst = 0; run = 1;
    tick();

    // 1) Demand read alone, response three cycles after the first request cycle.
    dem_read = 1; dem_address = 32'h0000_1234;
    tick();
    check("t1_mem_read",  mem_read, 1);
    check("t1_mem_addr",  mem_address, 32'h0000_1220);
    tick(); tick(); tick();
    mem_resp = 1; mem_rdata = a5; #1;
    check("t1_dem_resp",  dem_resp, 1);
    check("t1_dem_rdata", dem_rdata, a5);
    check("t1_pf_resp",   pf_resp, 0);
    tick(); idle_inputs(); #1;
    check("t1_mem_read_off", mem_read, 0);
    tick();

    // 2) Demand write.
    dem_write = 1; dem_address = 32'h40; dem_wdata = wpat;
    tick();
    check("t2_mem_write", mem_write, 1);
    check("t2_mem_read",  mem_read, 0);
    check("t2_mem_addr",  mem_address, 32'h40);
    check("t2_mem_wdata", mem_wdata, wpat);
    tick();
    mem_resp = 1; mem_rdata = d1; #1;
    check("t2_dem_resp", dem_resp, 1);
    tick(); idle_inputs(); #1;
    check("t2_mem_write_off", mem_write, 0);
    tick();

    // 3) Priority: demand first, then the waiting prefetch.
    dem_read = 1; dem_address = 32'h100; pf_read = 1; pf_address = 32'h200;
    tick();
    check("t3_first_addr", mem_address, 32'h100);
    tick();
    mem_resp = 1; mem_rdata = d1; #1;
    check("t3_dem_resp", dem_resp, 1);
    check("t3_pf_wait",  pf_resp, 0);
    tick(); dem_read = 0; mem_resp = 0; #1;
    check("t3_gap", mem_read, 0);
    tick();
    check("t3_pf_read", mem_read, 1);
    check("t3_pf_addr", mem_address, 32'h200);
    tick();
    mem_resp = 1; mem_rdata = d2; #1;
    check("t3_pf_resp",    pf_resp, 1);
    check("t3_pf_rdata",   pf_rdata, d2);
    check("t3_dem_quiet",  dem_resp, 0);
    tick(); idle_inputs();
    tick();

    // 4) Merge of same-line demand read and prefetch.
    dem_read = 1; dem_address = 32'h300; pf_read = 1; pf_address = 32'h31C;
    tick();
    check("t4_addr", mem_address, 32'h300);
    tick();
    mem_resp = 1; mem_rdata = d3; #1;
    check("t4_dem_resp",  dem_resp, 1);
    check("t4_pf_resp",   pf_resp, 1);
    check("t4_dem_rdata", dem_rdata, d3);
    check("t4_pf_rdata",  pf_rdata, d3);
    tick(); idle_inputs(); #1;
    check("t4_no_second_a", mem_read, 0);
    tick();
    check("t4_no_second_b", mem_read, 0);

    // 5) Non-preemption of a granted prefetch.
    pf_read = 1; pf_address = 32'h500;
    tick();
    check("t5_pf_addr", mem_address, 32'h500);
    dem_read = 1; dem_address = 32'h600;
    tick();
    check("t5_hold_addr", mem_address, 32'h500);
    mem_resp = 1; mem_rdata = d4; #1;
    check("t5_pf_resp",  pf_resp, 1);
    check("t5_dem_wait", dem_resp, 0);
    tick(); pf_read = 0; mem_resp = 0;
    tick();
    check("t5_dem_addr", mem_address, 32'h600);
    check("t5_dem_read", mem_read, 1);
    mem_resp = 1; mem_rdata = d1; #1;
    check("t5_dem_resp", dem_resp, 1);
    tick(); idle_inputs();
    tick();

    // 6) Asynchronous reset mid-demand, then a stray mem_resp.
    dem_read = 1; dem_address = 32'h700;
    tick();
    tick();
    #2 rst = 1; #1;
    check("t6_async_read", mem_read, 0);
    check("t6_async_addr", mem_address, 0);
    dem_read = 0;
    tick(); rst = 0;
    tick();
    mem_resp = 1; mem_rdata = d2; #1;
    check("t6_stray_dem", dem_resp, 0);
    check("t6_stray_pf",  pf_resp, 0);
    check("t6_stray_rd",  mem_read, 0);
    tick(); idle_inputs();
    tick(); tick();

    run = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Safety bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cline_mem_arbiter.md
# cline_mem_arbiter

Two-requester arbiter that shares the single 256-bit cacheline memory port between the demand path (cache miss read/writeback) and the next-line prefetcher. It sits between the cache/prefetcher pair and physical memory. Demand always has priority at grant time. A granted transaction is never preempted. A prefetch and a demand read of the same line are merged into one memory read.

## Interface
- ADDR_W, 32, byte address width
- LINE_W, 256, cacheline data width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- dem_read  in  1  demand line read request; level, held until dem_resp
- dem_write  in  1  demand line write request; level, held until dem_resp
- dem_address  in  ADDR_W  demand address; stable while request is high
- dem_wdata  in  LINE_W  write line data; stable while dem_write is high
- dem_rdata  out  LINE_W  read data; valid only while dem_resp is high
- dem_resp  out  1  one-cycle completion pulse
- pf_read  in  1  prefetch line read request; level, held until pf_resp
- pf_address  in  ADDR_W  prefetch address; stable while pf_read is high
- pf_rdata  out  LINE_W  read data; valid only while pf_resp is high
- pf_resp  out  1  one-cycle completion pulse
- mem_read, mem_write  out  1  memory-side request, level
- mem_address  out  ADDR_W  line-aligned; bits [4:0] are always 0
- mem_wdata  out  LINE_W  write data to memory
- mem_rdata  in  LINE_W  memory read data, valid with mem_resp
- mem_resp  in  1  memory completion pulse

## Operation
- States: IDLE, DEM, PF, MERGE. Reset puts the block in IDLE.
- Registered request latch: op (read/write), line address (address with [4:0] cleared), wdata.
- In IDLE, each cycle evaluates in this order:
  - dem_write high -> latch write, go to DEM. dem_write wins if dem_read is also high; that input combination is illegal.
  - dem_read and pf_read both high with equal address[31:5] -> latch read, go to MERGE.
  - dem_read high -> latch read, go to DEM. A concurrent prefetch waits.
  - pf_read high -> latch read, go to PF.
  - Otherwise stay in IDLE.
- In DEM, PF and MERGE: mem_read or mem_write is driven from the latched op, and mem_address/mem_wdata come from the latch. The block holds the state until mem_resp.
- On mem_resp, the block returns to IDLE on the next edge:
  - DEM: dem_resp=1 and dem_rdata=mem_rdata, combinationally in the same cycle.
  - PF: pf_resp=1 and pf_rdata=mem_rdata.
  - MERGE: both resp pulses, both rdata=mem_rdata.
  - For writes, dem_rdata is don't-care.
- mem_resp in IDLE is ignored: no resp pulses and no state change.
- The arbiter never changes the latched address or data mid-transaction, even if requester inputs change. Requester inputs are sampled only at grant.

## Timing
- Reset values: mem_read=0, mem_write=0, mem_address=0, mem_wdata=0, dem_resp=0, pf_resp=0, dem_rdata=0, pf_rdata=0, state=IDLE.
- Grant latency: request visible in IDLE at cycle t -> mem_read/mem_write high from cycle t+1.
- Completion: mem_resp at cycle k -> requester resp in cycle k. Memory request is low from cycle k+1. The arbiter is in IDLE at k+1 and can grant a new request at k+1, with the memory request reasserting at k+2.
- Minimum gap between memory transactions: 1 idle cycle.
- Requesters drop read/write in the cycle after their resp. A still-high request at k+1 is treated as a new request.
- Prefetch waiting behind demand: pf_read stays high. It is granted in the first IDLE cycle with no demand request. Prefetch starvation is permitted.
- Reset asserted mid-transaction: all outputs go to reset values immediately (asynchronous). A late mem_resp after reset release is ignored because the block is in IDLE.

## Test plan
- Demand read alone: dem_read=1, dem_address=0x0000_1234 at t -> mem_read=1 and mem_address=0x0000_1220 from t+1. mem_resp at t+4 with mem_rdata=0xA5..A5 -> dem_resp=1 and dem_rdata=0xA5..A5 at t+4. mem_read=0 at t+5. pf_resp stays 0.
- Demand write: dem_write=1, dem_address=0x40, dem_wdata=0x1122..FF -> mem_write=1, mem_address=0x40, mem_wdata matches. dem_resp pulses in the mem_resp cycle. mem_read never asserts.
- Priority: dem_read at 0x100 and pf_read at 0x200 in the same IDLE cycle -> demand read of 0x100 is issued first. After its resp and one IDLE cycle, mem_read of 0x200 is issued and pf_resp pulses on that transaction's mem_resp.
- Merge: dem_read at 0x300 and pf_read at 0x31C simultaneously -> a single mem_read of 0x300. dem_resp and pf_resp both pulse in the mem_resp cycle with identical rdata. No second memory transaction follows.
- Non-preemption: pf granted for 0x500, then dem_read at 0x600 arrives before mem_resp -> mem_address stays 0x500 until resp. Demand is issued at 0x600 afterward.
- Async reset mid-DEM, plus a stray mem_resp: assert rst two cycles after grant -> mem_read=0 without waiting for a clock edge. A mem_resp one cycle after reset release produces no dem_resp or pf_resp.
